multiplier_datapath_taint_word: RTL
===================================

Name: multiplier_datapath_taint_word

Overview:
- Datapath half of the sequential shift-add multiplier, with word-granularity taint tracking.
- Holds the multiplicand (MD), multiplier (MR) and result/shift (RS) registers.
- Acts on the control strobes rsclear/rsload/rsshr/mrld/mdld and their taint bits.
- Returns multiplierReg and multiplierReg_t to the control FSM. Every data word carries one taint bit; tainted control strobes taint the registers they target.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- multiplicand  in  WIDTH  operand loaded into MD
- multiplicand_t  in  1  taint of multiplicand
- multiplier  in  WIDTH  operand loaded into MR
- multiplier_t  in  1  taint of multiplier
- mdld, mdld_t  in  1,1  load MD / taint
- mrld, mrld_t  in  1,1  load MR / taint
- rsclear, rsclear_t  in  1,1  clear RS / taint
- rsload, rsload_t  in  1,1  add MD into RS upper half / taint
- rsshr, rsshr_t  in  1,1  shift RS right by 1 / taint
- multiplierReg  out  WIDTH  MR contents, to control
- multiplierReg_t  out  1  MR taint
- product  out  2*WIDTH  RS[2W-1:0]
- product_t  out  1  RS taint
- ctrl_conflict  out  1  sticky: illegal strobe combination seen

Behaviour:
- Registers:
  - MD: WIDTH bits.
  - MR: WIDTH bits.
  - RS: 2*WIDTH+1 bits; bit 2W is the adder carry.
  - One taint bit each: md_t, mr_t, rs_t.
  - conflict flag.
- Reset: all registers, all taints and ctrl_conflict are 0. Consequently product=0, product_t=0, multiplierReg=0, multiplierReg_t=0.
- Reset mid-operation has the same effect.
- All updates occur on posedge clk; outputs are direct register outputs with zero combinational latency.
- MD load:
  - mdld=1: MD<=multiplicand; md_t<=multiplicand_t|mdld_t.
  - mdld=0: MD holds; md_t<=md_t|mdld_t.
- MR load follows the same rule with mrld, multiplier and multiplier_t.
- RS priority: rsclear > rsload > rsshr.
  - rsclear: RS<=0; rs_t<=rsclear_t. Clear discards old taint.
  - rsload: RS[2W:W]<={1'b0,RS[2W-1:W]}+MD, computed at W+1 bits; RS[W-1:0] holds. rs_t<=rs_t|md_t|rsload_t.
  - rsshr: RS<=RS>>1, zero-filled; rs_t<=rs_t|rsshr_t.
  - No RS strobe: RS holds. rs_t<=rs_t|rsload_t|rsshr_t, because a tainted deasserted strobe still taints RS. When rsclear=0, rsclear_t is ORed into rs_t.
- Control sequence per product:
  - INIT cycle: mdld+mrld+rsclear.
  - Then WIDTH+1 rsshr cycles, with an optional rsload cycle between consecutive shifts for bit k of MR.
  - Final result is valid the cycle after the last rsshr.
  - Arithmetic: product = MD*MR mod 2^(2W); no overflow is possible.
- ctrl_conflict: set when more than one of rsclear/rsload/rsshr is asserted in one cycle, or when rsload and mdld are both asserted. Cleared only by rst. The priority rule above still applies in a conflict cycle.
- mdld/mrld concurrent with RS strobes is legal. The RS update uses the old MD value.

Optional Feature:
- Macro MULT_DP_PRODUCT_HOLD_EN.
- Defined:
  - Adds inputs productDone and productDone_t.
  - Adds outputs product_hold (2*WIDTH), product_hold_t and hold_valid.
  - The cycle after productDone=1, product_hold<=RS[2W-1:0] (post-final-shift), product_hold_t<=rs_t|productDone_t, and hold_valid<=1.
  - hold_valid clears on the next rsclear.
  - rst zeroes all three outputs.
  - productDone_t=1 with productDone=0 still ORs into product_hold_t.
- Undefined: the ports and logic are absent; product is the only result.

Test Plan:
- W=4, MD=13, MR=11, untainted; drive INIT then shift/load sequence for bits 1,1,0,1 -> product=143 (0x8F), product_t=0, ctrl_conflict=0.
- W=4, MD=15, MR=15 -> product=225 (0xE1). Carry is exercised; RS[8] is 0 after the final shift.
- multiplicand_t=1, MR=0 (no rsload pulses), all strobe taints 0 -> product=0, product_t=0. multiplicand_t=1, MR=1 -> product_t=1.
- Untainted operands, rsload_t=1 held during one non-load cycle -> product_t=1. A following rsclear with rsclear_t=0 -> product_t=0.
- rsload=1 and rsshr=1 in the same cycle -> RS takes the add result, ctrl_conflict=1 until rst. rst mid-product -> all outputs 0 on the next cycle.
- MULT_DP_PRODUCT_HOLD_EN defined, 13*11 run with productDone pulsed on the final shift -> the next cycle gives product_hold=143, hold_valid=1. A new INIT (rsclear) -> hold_valid=0.

Source files
------------

// File: rtl/multiplier_datapath_taint_word_if.sv
// rtl/multiplier_datapath_taint_word_if.sv - strobe/operand/result bundle for the taint-tracking multiplier datapath
// Optional product-hold signals exist only when MULT_DP_PRODUCT_HOLD_EN is defined.
interface multiplier_datapath_taint_word_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0]   multiplicand;
   logic               multiplicand_t;
   logic [WIDTH-1:0]   multiplier;
   logic               multiplier_t;
   logic               mdld;
   logic               mdld_t;
   logic               mrld;
   logic               mrld_t;
   logic               rsclear;
   logic               rsclear_t;
   logic               rsload;
   logic               rsload_t;
   logic               rsshr;
   logic               rsshr_t;
   logic [WIDTH-1:0]   multiplierReg;
   logic               multiplierReg_t;
   logic [2*WIDTH-1:0] product;
   logic               product_t;
   logic               ctrl_conflict;
`ifdef MULT_DP_PRODUCT_HOLD_EN
   logic               productDone;
   logic               productDone_t;
   logic [2*WIDTH-1:0] product_hold;
   logic               product_hold_t;
   logic               hold_valid;
`endif

   modport master (
      output multiplicand, multiplicand_t, multiplier, multiplier_t,
      output mdld, mdld_t, mrld, mrld_t,
      output rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
`ifdef MULT_DP_PRODUCT_HOLD_EN
      output productDone, productDone_t,
      input  product_hold, product_hold_t, hold_valid,
`endif
      input  multiplierReg, multiplierReg_t, product, product_t, ctrl_conflict
   );

   modport slave (
      input  multiplicand, multiplicand_t, multiplier, multiplier_t,
      input  mdld, mdld_t, mrld, mrld_t,
      input  rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t,
`ifdef MULT_DP_PRODUCT_HOLD_EN
      input  productDone, productDone_t,
      output product_hold, product_hold_t, hold_valid,
`endif
      output multiplierReg, multiplierReg_t, product, product_t, ctrl_conflict
   );
endinterface

// File: rtl/multiplier_datapath_taint_word.sv
// rtl/multiplier_datapath_taint_word.sv - shift-add multiplier datapath (MD/MR/RS) with one taint bit per word
// Optional result hold register enabled by MULT_DP_PRODUCT_HOLD_EN.
module multiplier_datapath_taint_word #(
   parameter int WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   multiplier_datapath_taint_word_if.slave   bus
);
   logic [WIDTH-1:0]   md;
   logic [WIDTH-1:0]   mr;
   logic [2*WIDTH:0]   rs;
   logic               md_t;
   logic               mr_t;
   logic               rs_t;
   logic               conflict;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH:0]   rs_n;
   logic               rs_t_n;
   logic [1:0]         n_strobes;
   logic               conflict_n;

   // Upper-half add uses the pre-update MD, so a same-cycle mdld does not affect it.
   assign sum       = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
   assign n_strobes = 2'(bus.rsclear) + 2'(bus.rsload) + 2'(bus.rsshr);
   assign conflict_n = (n_strobes > 2'd1) || (bus.rsload && bus.mdld);

   always_comb begin
      rs_n   = rs;
      rs_t_n = rs_t | bus.rsclear_t | bus.rsload_t | bus.rsshr_t;
      if (bus.rsclear) begin
         rs_n   = '0;
         rs_t_n = bus.rsclear_t;
      end else if (bus.rsload) begin
         rs_n   = {sum, rs[WIDTH-1:0]};
         rs_t_n = rs_t_n | md_t;
      end else if (bus.rsshr) begin
         rs_n = rs >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md       <= '0;
         mr       <= '0;
         rs       <= '0;
         md_t     <= 1'b0;
         mr_t     <= 1'b0;
         rs_t     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         if (bus.mdld) md <= bus.multiplicand;
         md_t <= (bus.mdld ? bus.multiplicand_t : md_t) | bus.mdld_t;
         if (bus.mrld) mr <= bus.multiplier;
         mr_t <= (bus.mrld ? bus.multiplier_t : mr_t) | bus.mrld_t;
         rs   <= rs_n;
         rs_t <= rs_t_n;
         if (conflict_n) conflict <= 1'b1;
      end
   end

   assign bus.multiplierReg   = mr;
   assign bus.multiplierReg_t = mr_t;
   assign bus.product         = rs[2*WIDTH-1:0];
   assign bus.product_t       = rs_t;
   assign bus.ctrl_conflict   = conflict;

`ifdef MULT_DP_PRODUCT_HOLD_EN
   logic [2*WIDTH-1:0] hold;
   logic               hold_t;
   logic               valid;

   // Captures the post-update RS so a done pulse on the final shift holds the finished product.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold   <= '0;
         hold_t <= 1'b0;
         valid  <= 1'b0;
      end else if (bus.productDone) begin
         hold   <= rs_n[2*WIDTH-1:0];
         hold_t <= rs_t_n | bus.productDone_t;
         valid  <= 1'b1;
      end else begin
         hold_t <= hold_t | bus.productDone_t;
         if (bus.rsclear) valid <= 1'b0;
      end
   end

   assign bus.product_hold   = hold;
   assign bus.product_hold_t = hold_t;
   assign bus.hold_valid     = valid;
`endif
endmodule
